if_fetch_ctrl: RTL and testbench

Sequences the instruction-fetch stage of the RV32IM core. It owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake. Returned instructions go into a 2-entry fetch buffer that feeds ID under a valid/ready handshake. Branch/jump redirects from EX flush the buffer and drop in-flight responses.

---
 rtl/if_ctrl_pkg.sv | 12 +
 rtl/if_fetch_buf.sv | 52 +++++
 rtl/if_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_ctrl_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, buffer entry, buffer depth.
package if_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} fetch_state_e;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int XLEN            = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_buf.sv
// 2-entry fetch FIFO; entry 0 is always the head. Clear wins over push/pop.
module if_fetch_buf
  import if_ctrl_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);
  logic [FETCH_BUF_DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [1:0] count_q, count_d, cnt_tmp;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    cnt_tmp = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      if (pop && count_q != 2'd0) begin
        mem_d[0] = mem_q[1];
        cnt_tmp  = count_q - 2'd1;
      end
      // write lands at the slot freed by a same-cycle pop, preserving order
      if (push && cnt_tmp != 2'(FETCH_BUF_DEPTH)) begin
        if (cnt_tmp == 2'd0) mem_d[0] = din;
        else                 mem_d[1] = din;
        cnt_tmp = cnt_tmp + 2'd1;
      end
      count_d = cnt_tmp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? mem_q[0] : '0;
endmodule

// File: rtl/if_fetch_ctrl.sv
// RV32IM fetch sequencer: one outstanding imem request, 2-entry buffer to ID, EX redirects.
// Optional perf counters under `define IF_FETCH_PERF_EN.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int                  AddrSize  = 32,
  parameter int                  Inst_Size = 32,
  parameter logic [AddrSize-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PC_Select,
  input  logic                 Jump_Sel,
  input  logic [AddrSize-1:0]  Added_PC_from_Branch,
  input  logic [AddrSize-1:0]  Added_PC_from_Jump,
  output logic                 imem_req,
  output logic [AddrSize-1:0]  imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [Inst_Size-1:0] imem_rdata,
  output logic                 if_valid,
  input  logic                 id_ready,
  output logic [Inst_Size-1:0] Inst,
  output logic [AddrSize-1:0]  PC_Curr,
  output logic [AddrSize-1:0]  PC_Temp
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);
  localparam int DW = AddrSize + Inst_Size;

  fetch_state_e        state_q, state_d;
  logic [AddrSize-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, target, head_pc;
  logic [Inst_Size-1:0] head_inst;
  logic [DW-1:0]       head;
  logic [1:0]          count;
  logic                gnt_acc, push, pop, drop;

  assign target   = Jump_Sel ? Added_PC_from_Jump : Added_PC_from_Branch;
  assign imem_req = (state_q == REQ) && (count != 2'(FETCH_BUF_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign gnt_acc  = imem_req && imem_gnt;
  assign push     = (state_q == WAIT) && imem_rvalid && !PC_Select;
  assign drop     = imem_rvalid && (((state_q == WAIT) && PC_Select) || (state_q == FLUSH));
  assign if_valid = (count != 2'd0);
  assign pop      = if_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (gnt_acc) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + AddrSize'(4);
    end
    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   if (gnt_acc) state_d = PC_Select ? FLUSH : WAIT;
      WAIT:  if (imem_rvalid) state_d = REQ;
             else if (PC_Select) state_d = FLUSH;
      // the stale response is consumed even if another redirect lands with it,
      // otherwise FLUSH would wait for a response that never comes
      FLUSH: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (PC_Select) fetch_pc_d = target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  if_fetch_buf #(.DW(DW)) u_buf (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .clear (PC_Select),
    .din   ({req_pc_q, imem_rdata}),
    .count (count),
    .head  (head)
  );

  assign {head_pc, head_inst} = head;
  assign Inst    = head_inst;
  assign PC_Curr = head_pc;
  assign PC_Temp = if_valid ? head_pc + AddrSize'(4) : '0;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    stall_cnt_d = stall_cnt_q + 32'(if_valid && !id_ready);
    flush_cnt_d = flush_cnt_q + 32'(drop) + (PC_Select ? 32'(count) : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl against a transaction-level model (request epochs + entry queue).
module tb_if_fetch_ctrl;
  import if_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_Select, Jump_Sel;
  logic [31:0] Added_PC_from_Branch, Added_PC_from_Jump;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, id_ready;
  logic [31:0] Inst, PC_Curr, PC_Temp;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  if_fetch_ctrl #(.AddrSize(32), .Inst_Size(32), .RESET_PC(32'h0)) dut (
    .clk                  (clk),
    .reset                (reset),
    .PC_Select            (PC_Select),
    .Jump_Sel             (Jump_Sel),
    .Added_PC_from_Branch (Added_PC_from_Branch),
    .Added_PC_from_Jump   (Added_PC_from_Jump),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_gnt             (imem_gnt),
    .imem_rvalid          (imem_rvalid),
    .imem_rdata           (imem_rdata),
    .if_valid             (if_valid),
    .id_ready             (id_ready),
    .Inst                 (Inst),
    .PC_Curr              (PC_Curr),
    .PC_Temp              (PC_Temp)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt       (perf_fetch_cnt),
    .perf_stall_cnt       (perf_stall_cnt),
    .perf_flush_cnt       (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0;
  int gnt_pct, dly_max, sel_pct, rdy_pct;
  bit dir_js;
  logic [31:0] dir_bt, dir_jt;

  // model: entries ID should see, expected next fetch address, one outstanding request tagged by epoch
  fetch_entry_t q[$];
  logic [31:0] exp_fetch, out_addr;
  bit          started, outst;
  int          dly, out_ep, epoch;
  logic [31:0] m_fetch, m_stall, m_flush;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_fetch = 32'h0; out_addr = '0;
    started = 0; outst = 0; dly = 0; out_ep = 0; epoch = 0;
    m_fetch = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive_idle();
    PC_Select = 0; Jump_Sel = 0; Added_PC_from_Branch = '0; Added_PC_from_Jump = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // One cycle: compare outputs with model, drive inputs, advance model at the edge.
  // mode 1: redirect when a request is waiting with no rvalid; mode 2: redirect on a grant.
  task automatic cycle(input int mode, output bit fired);
    bit exp_req, rv, g, sel, js, rdy, acc;
    logic [31:0] bt, jt, tgt, rd;
    exp_req = started && !outst && (q.size() < 2);

    chk_cnt++;
    if (imem_req !== exp_req) $display("FAIL imem_req act=%0b exp=%0b t=%0t", imem_req, exp_req, $time);
    else pass_cnt++;
    if (exp_req) begin
      chk_cnt++;
      if (imem_addr !== exp_fetch) $display("FAIL imem_addr act=%h exp=%h t=%0t", imem_addr, exp_fetch, $time);
      else pass_cnt++;
    end
    chk_cnt++;
    if (if_valid !== (q.size() != 0)) $display("FAIL if_valid act=%0b exp=%0b t=%0t", if_valid, q.size() != 0, $time);
    else pass_cnt++;
    chk_cnt++;
    if (q.size() != 0) begin
      if ({PC_Curr, Inst, PC_Temp} !== {q[0].pc, q[0].inst, q[0].pc + 32'd4})
        $display("FAIL head act=%h/%h/%h exp=%h/%h/%h t=%0t", PC_Curr, Inst, PC_Temp,
                 q[0].pc, q[0].inst, q[0].pc + 32'd4, $time);
      else pass_cnt++;
    end else begin
      if ({PC_Curr, Inst, PC_Temp} !== 96'h0)
        $display("FAIL empty_head act=%h/%h/%h exp=0 t=%0t", PC_Curr, Inst, PC_Temp, $time);
      else pass_cnt++;
    end
`ifdef IF_FETCH_PERF_EN
    chk_cnt++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== {m_fetch, m_stall, m_flush})
      $display("FAIL perf act=%0d/%0d/%0d exp=%0d/%0d/%0d t=%0t", perf_fetch_cnt, perf_stall_cnt,
               perf_flush_cnt, m_fetch, m_stall, m_flush, $time);
    else pass_cnt++;
`endif

    rv  = outst && (dly == 0);
    g   = int'($urandom_range(99)) < gnt_pct;
    rdy = int'($urandom_range(99)) < rdy_pct;
    sel = int'($urandom_range(99)) < sel_pct;
    js  = $urandom_range(1) == 1;
    bt  = $urandom;
    jt  = $urandom;
    if (mode != 0) begin
      sel = (mode == 1) ? (outst && !rv) : (exp_req && g);
      js = dir_js; bt = dir_bt; jt = dir_jt;
    end
    fired = sel;
    rd  = rv ? inst_of(out_addr) : $urandom;
    tgt = js ? jt : bt;
    PC_Select = sel; Jump_Sel = js; Added_PC_from_Branch = bt; Added_PC_from_Jump = jt;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy;

    @(posedge clk);
    if (q.size() != 0 && !rdy) m_stall++;
    acc = 0;
    if (rv) begin
      outst = 0;
      if (!sel && out_ep == epoch) begin acc = 1; m_fetch++; end
      else m_flush++;
    end
    if (sel) begin
      m_flush += q.size();
      q.delete();
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back('{pc: out_addr, inst: inst_of(out_addr)});
    end
    if (exp_req && g) begin
      outst = 1; out_addr = exp_fetch; out_ep = epoch;
      dly = int'($urandom_range(dly_max));
      if (!sel) exp_fetch = exp_fetch + 32'd4;
    end else if (outst && dly > 0) begin
      dly--;
    end
    if (sel) begin epoch++; exp_fetch = tgt; end
    started = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit f;
    for (int i = 0; i < n; i++) cycle(0, f);
  endtask

  // redirect once under the given mode, then check the first entry ID sees is the target
  task automatic redirect_and_check(input string name, input int mode, input logic [31:0] exp_pc);
    bit f, got;
    f = 0;
    for (int i = 0; i < 40 && !f; i++) cycle(mode, f);
    chk_cnt++;
    if (!f) $display("FAIL %s_trigger act=0 exp=1", name);
    else pass_cnt++;
    rdy_pct = 100;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (if_valid === 1'b1) got = 1;
      else run(1);
    end
    chk_cnt++;
    if (!got || PC_Curr !== exp_pc) $display("FAIL %s_first_pc act=%h valid=%0b exp=%h", name, PC_Curr, got, exp_pc);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #1;
    chk_cnt++;
    if ({imem_req, if_valid, Inst, PC_Curr, PC_Temp} !== 98'h0)
      $display("FAIL reset_outputs act=%0b/%0b/%h/%h/%h exp=0", imem_req, if_valid, Inst, PC_Curr, PC_Temp);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_zero_wait();
    bit f;
    gnt_pct = 100; dly_max = 0; sel_pct = 0; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (if_valid !== (i == 3)) $display("FAIL first_valid_cycle c=%0d act=%0b exp=%0b", i, if_valid, i == 3);
      else pass_cnt++;
      if (i == 3) begin
        chk_cnt++;
        if (PC_Curr !== 32'h0 || PC_Temp !== 32'h4) $display("FAIL first_head act=%h/%h exp=0/4", PC_Curr, PC_Temp);
        else pass_cnt++;
      end
      cycle(0, f);
    end
    run(20);
  endtask

  task automatic test_backpressure();
    rdy_pct = 0;
    run(12);
    chk_cnt++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1) $display("FAIL full_hold act=%0b/%0b exp=0/1", imem_req, if_valid);
    else pass_cnt++;
    rdy_pct = 100;
    run(20);
  endtask

  task automatic test_redirect_wait();
    gnt_pct = 100; dly_max = 3; sel_pct = 0; rdy_pct = 100;
    dir_js = 1; dir_jt = 32'h100; dir_bt = 32'hDEAD_0000;
    redirect_and_check("redir_wait", 1, 32'h100);
    run(10);
  endtask

  task automatic test_redirect_gnt();
    gnt_pct = 100; dly_max = 0; sel_pct = 0; rdy_pct = 100;
    dir_js = 0; dir_bt = 32'h40; dir_jt = 32'hBEEF_0000;
    redirect_and_check("redir_gnt", 2, 32'h40);
    run(10);
  endtask

  task automatic test_wrap();
    bit got;
    gnt_pct = 100; dly_max = 0; sel_pct = 0; rdy_pct = 100;
    dir_js = 1; dir_jt = 32'hFFFF_FFFC; dir_bt = 32'h0;
    redirect_and_check("wrap", 2, 32'hFFFF_FFFC);
    chk_cnt++;
    if (PC_Temp !== 32'h0) $display("FAIL wrap_pc_temp act=%h exp=0", PC_Temp);
    else pass_cnt++;
    run(1);
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (if_valid === 1'b1) got = 1;
      else run(1);
    end
    chk_cnt++;
    if (!got || PC_Curr !== 32'h0) $display("FAIL wrap_next_pc act=%h exp=0", PC_Curr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    gnt_pct = 60; dly_max = 3; sel_pct = 8; rdy_pct = 60;
    run(2000);
  endtask

  task automatic test_async_reset();
    bit f, hit;
    gnt_pct = 100; dly_max = 3; sel_pct = 0; rdy_pct = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (outst && dly > 0 && q.size() != 0) hit = 1;
      else cycle(0, f);
    end
    chk_cnt++;
    if (!hit) $display("FAIL async_setup act=0 exp=1");
    else pass_cnt++;
    reset = 1'b1;
    drive_idle();
    #2;
    chk_cnt++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) $display("FAIL async_drop act=%0b/%0b exp=0/0", imem_req, if_valid);
    else pass_cnt++;
    do_reset();
`ifdef IF_FETCH_PERF_EN
    chk_cnt++;
    if ({perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt} !== 96'h0)
      $display("FAIL perf_reset act=%0d/%0d/%0d exp=0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
    else pass_cnt++;
`endif
    gnt_pct = 100; dly_max = 0; rdy_pct = 100;
    run(3);
    chk_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL restart_addr act=%0b/%h exp=1/4", imem_req, imem_addr);
    else pass_cnt++;
    run(10);
  endtask

  initial begin
    gnt_pct = 100; dly_max = 0; sel_pct = 0; rdy_pct = 100;
    dir_js = 0; dir_bt = '0; dir_jt = '0;
    model_reset();
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
